// File: rtl/lcd_nibble_driver_if.sv
// rtl/lcd_nibble_driver_if.sv - sequencer-side request/response and LCD pad bundle for lcd_nibble_driver
interface lcd_nibble_driver_if;
   logic       sendCommand_tick;
   logic [3:0] commandToSend;
   logic       commandToSendRs;
   logic       read_busy;
   logic       commandDone;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [3:0] lcd_data_out;
   logic       lcd_data_oe;
   logic [3:0] lcd_data_in;
   logic       busy_timeout;

   modport master (
      output sendCommand_tick, commandToSend, commandToSendRs, read_busy, lcd_data_in,
      input  commandDone, lcd_e, lcd_rs, lcd_rw, lcd_data_out, lcd_data_oe, busy_timeout
   );

   modport slave (
      input  sendCommand_tick, commandToSend, commandToSendRs, read_busy, lcd_data_in,
      output commandDone, lcd_e, lcd_rs, lcd_rw, lcd_data_out, lcd_data_oe, busy_timeout
   );
endinterface

// File: rtl/lcd_nibble_driver.sv
// rtl/lcd_nibble_driver.sv - HD44780 4-bit bus nibble writer with optional busy-flag polling
// Optional bounded busy poll with sticky busy_timeout: define LCD_BUSY_TIMEOUT_EN.
module lcd_nibble_driver #(
   parameter int unsigned SETUP_CYCLES   = 2,
   parameter int unsigned E_HIGH_CYCLES  = 12,
   parameter int unsigned HOLD_CYCLES    = 12,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                 CLK,
   input  logic                 RESET,
   lcd_nibble_driver_if.slave   bus
);
   localparam int unsigned M1   = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
   localparam int unsigned M2   = (M1 > HOLD_CYCLES) ? M1 : HOLD_CYCLES;
   localparam int unsigned MAXP = (M2 > TIMEOUT_CYCLES) ? M2 : TIMEOUT_CYCLES;
   localparam int unsigned CW   = $clog2(MAXP) + 1;

   typedef enum logic [3:0] {
      IDLE, W_SETUP, W_EHI, W_HOLD,
      BF_SETUP, BF_E1HI, BF_E1HOLD, BF_E2HI, BF_E2HOLD,
      DONE
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_rd_busy;
   logic          r_bf;
   logic          r_e;
   logic          r_rs;
   logic          r_rw;
   logic          r_oe;
   logic          r_done;
   logic [3:0]    r_data;

   logic w_last_setup;
   logic w_last_ehi;
   logic w_last_hold;
   logic w_in_poll;

   assign w_last_setup = (r_cnt == CW'(SETUP_CYCLES - 1));
   assign w_last_ehi   = (r_cnt == CW'(E_HIGH_CYCLES - 1));
   assign w_last_hold  = (r_cnt == CW'(HOLD_CYCLES - 1));
   assign w_in_poll    = (r_state == BF_SETUP)  || (r_state == BF_E1HI) ||
                         (r_state == BF_E1HOLD) || (r_state == BF_E2HI) ||
                         (r_state == BF_E2HOLD);

`ifdef LCD_BUSY_TIMEOUT_EN
   logic [CW-1:0] r_poll_cnt;
   logic          r_timeout;
   logic          w_poll_expired;

   // A clean BF=0 exit on the very last poll cycle wins over the timeout.
   assign w_poll_expired = w_in_poll && (r_poll_cnt == CW'(TIMEOUT_CYCLES - 1)) &&
                           !((r_state == BF_E2HOLD) && w_last_hold && !r_bf);
   assign bus.busy_timeout = r_timeout;
`else
   assign bus.busy_timeout = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_rd_busy <= 1'b0;
         r_bf      <= 1'b0;
         r_e       <= 1'b0;
         r_rs      <= 1'b0;
         r_rw      <= 1'b0;
         r_oe      <= 1'b1;
         r_done    <= 1'b0;
         r_data    <= 4'h0;
`ifdef LCD_BUSY_TIMEOUT_EN
         r_poll_cnt <= '0;
         r_timeout  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         r_cnt  <= r_cnt + CW'(1);
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (bus.sendCommand_tick) begin
                  r_data    <= bus.commandToSend;
                  r_rs      <= bus.commandToSendRs;
                  r_rd_busy <= bus.read_busy;
                  r_rw      <= 1'b0;
                  r_oe      <= 1'b1;
                  r_state   <= W_SETUP;
               end
            end
            W_SETUP: if (w_last_setup) begin
               r_e     <= 1'b1;
               r_cnt   <= '0;
               r_state <= W_EHI;
            end
            W_EHI: if (w_last_ehi) begin
               r_e     <= 1'b0;
               r_cnt   <= '0;
               r_state <= W_HOLD;
            end
            W_HOLD: if (w_last_hold) begin
               r_cnt <= '0;
               if (r_rd_busy) begin
                  r_rs    <= 1'b0;
                  r_rw    <= 1'b1;
                  r_oe    <= 1'b0;
                  r_state <= BF_SETUP;
`ifdef LCD_BUSY_TIMEOUT_EN
                  r_poll_cnt <= '0;
`endif
               end else begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            BF_SETUP: if (w_last_setup) begin
               r_e     <= 1'b1;
               r_cnt   <= '0;
               r_state <= BF_E1HI;
            end
            BF_E1HI: if (w_last_ehi) begin
               r_bf    <= bus.lcd_data_in[3];
               r_e     <= 1'b0;
               r_cnt   <= '0;
               r_state <= BF_E1HOLD;
            end
            BF_E1HOLD: if (w_last_hold) begin
               r_e     <= 1'b1;
               r_cnt   <= '0;
               r_state <= BF_E2HI;
            end
            BF_E2HI: if (w_last_ehi) begin
               r_e     <= 1'b0;
               r_cnt   <= '0;
               r_state <= BF_E2HOLD;
            end
            BF_E2HOLD: if (w_last_hold) begin
               r_cnt <= '0;
               if (r_bf) begin
                  r_state <= BF_SETUP;
               end else begin
                  r_rw    <= 1'b0;
                  r_oe    <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_cnt   <= '0;
               r_state <= IDLE;
            end
            default: begin
               r_cnt   <= '0;
               r_state <= IDLE;
            end
         endcase
`ifdef LCD_BUSY_TIMEOUT_EN
         if (w_in_poll) begin
            r_poll_cnt <= r_poll_cnt + CW'(1);
            if (w_poll_expired) begin
               r_e       <= 1'b0;
               r_rw      <= 1'b0;
               r_oe      <= 1'b1;
               r_done    <= 1'b1;
               r_timeout <= 1'b1;
               r_cnt     <= '0;
               r_state   <= DONE;
            end
         end
`endif
      end
   end

   assign bus.commandDone  = r_done;
   assign bus.lcd_e        = r_e;
   assign bus.lcd_rs       = r_rs;
   assign bus.lcd_rw       = r_rw;
   assign bus.lcd_data_out = r_data;
   assign bus.lcd_data_oe  = r_oe;
endmodule

// File: tb/tb_lcd_nibble_driver.sv
// tb/tb_lcd_nibble_driver.sv - randomized check of lcd_nibble_driver against a timeline reference model
module tb_lcd_nibble_driver;
   localparam int S  = 2;
   localparam int E  = 12;
   localparam int H  = 12;
   localparam int TO = 200;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   lcd_nibble_driver_if bus ();

   lcd_nibble_driver #(
      .SETUP_CYCLES(S), .E_HIGH_CYCLES(E), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .bus(bus)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference timeline: a transfer is one write pulse then (polls) read pairs, each a fixed length.
   function automatic int exp_latency(input logic rb, input int nbusy);
      int pairs;
      pairs = rb ? nbusy + 1 : 0;
      return 1 + S + E + H + pairs * (S + 2 * E + 2 * H);
   endfunction

   task automatic run_txn(input logic [3:0] nib, input logic rs, input logic rb,
                          input int nbusy, input int inj_cyc);
      int lat, pairs, cyc, done_cnt, done_at, pulses, rd_pulses, run, bad_w;
      int bus_err, rw_err, oe_err, first_rise;
      logic rw_at_done, prev_e;
      pairs = rb ? nbusy + 1 : 0;
      lat   = exp_latency(rb, nbusy);
      {cyc, done_cnt, pulses, rd_pulses, run, bad_w, bus_err, rw_err, oe_err} = '0;
      done_at = -1; first_rise = -1; rw_at_done = 1'bx; prev_e = 1'b0;

      @(negedge CLK);
      bus.sendCommand_tick = 1'b1;
      bus.commandToSend    = nib;
      bus.commandToSendRs  = rs;
      bus.read_busy        = rb;
      while (cyc < lat + 4) begin
         @(negedge CLK);
         cyc++;
         bus.sendCommand_tick = (cyc == inj_cyc);
         if (cyc == inj_cyc) begin
            bus.commandToSend   = ~nib;
            bus.commandToSendRs = ~rs;
         end
         if (bus.lcd_data_oe !== ~bus.lcd_rw) oe_err++;
         if (bus.commandDone === 1'b1) begin
            done_cnt++;
            done_at    = cyc;
            rw_at_done = bus.lcd_rw;
         end
         if (cyc >= 1 && cyc <= S + E + H) begin
            if (bus.lcd_rw !== 1'b0 || bus.lcd_rs !== rs || bus.lcd_data_out !== nib) bus_err++;
         end
         if (bus.lcd_e === 1'b1) begin
            run++;
            if (!prev_e) begin
               pulses++;
               if (first_rise < 0) first_rise = cyc;
               if (bus.lcd_rw === 1'b1) begin
                  rd_pulses++;
                  if (rd_pulses % 2 == 1)
                     bus.lcd_data_in = {(((rd_pulses - 1) / 2) < nbusy), 3'($urandom)};
                  else
                     bus.lcd_data_in = 4'($urandom);
               end
            end
            if (cyc > S + E + H && (bus.lcd_rw !== 1'b1 || bus.lcd_rs !== 1'b0)) rw_err++;
         end else if (prev_e) begin
            if (run != E) bad_w++;
            run = 0;
         end
         prev_e = bus.lcd_e;
      end
      check_val("done_count", done_cnt, 1);
      check_val("done_cycle", done_at, lat);
      check_val("e_pulses", pulses, 1 + 2 * pairs);
      check_val("first_e_rise", first_rise, S + 1);
      check_val("e_width_errs", bad_w, 0);
      check_val("write_bus_errs", bus_err, 0);
      check_val("read_bus_errs", rw_err, 0);
      check_val("oe_errs", oe_err, 0);
      check_val("rw_at_done", rw_at_done, 0);
      check_val("idle_rs", bus.lcd_rs, rb ? 1'b0 : rs);
      check_val("idle_data", bus.lcd_data_out, nib);
      check_val("idle_e", bus.lcd_e, 0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1;
      bus.sendCommand_tick = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
   endtask

   initial begin
      int cyc, done_cnt, done_at;
      bus.sendCommand_tick = 1'b0;
      bus.commandToSend    = 4'h0;
      bus.commandToSendRs  = 1'b0;
      bus.read_busy        = 1'b0;
      bus.lcd_data_in      = 4'h0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      check_val("rst_e", bus.lcd_e, 0);
      check_val("rst_rs", bus.lcd_rs, 0);
      check_val("rst_rw", bus.lcd_rw, 0);
      check_val("rst_data", bus.lcd_data_out, 0);
      check_val("rst_oe", bus.lcd_data_oe, 1);
      check_val("rst_done", bus.commandDone, 0);
      check_val("rst_timeout", bus.busy_timeout, 0);

      run_txn(4'hA, 1'b1, 1'b0, 0, -1);
      run_txn(4'h3, 1'b0, 1'b1, 0, -1);
      run_txn(4'h5, 1'b1, 1'b1, 2, -1);
      run_txn(4'hC, 1'b1, 1'b0, 0, S + 5);
      for (int i = 0; i < 12; i++)
         run_txn(4'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : -1);

      // Reset landing inside the first busy-read E pulse.
      @(negedge CLK);
      bus.sendCommand_tick = 1'b1;
      bus.commandToSend    = 4'h9;
      bus.commandToSendRs  = 1'b1;
      bus.read_busy        = 1'b1;
      bus.lcd_data_in      = 4'hF;
      for (int c = 1; c <= S + E + H + S + 3; c++) begin
         @(negedge CLK);
         bus.sendCommand_tick = 1'b0;
      end
      check_val("pre_rst_e", bus.lcd_e, 1);
      #2 RESET = 1'b1;
      #1;
      check_val("async_rst_e", bus.lcd_e, 0);
      check_val("async_rst_rw", bus.lcd_rw, 0);
      check_val("async_rst_oe", bus.lcd_data_oe, 1);
      check_val("async_rst_done", bus.commandDone, 0);
      @(negedge CLK);
      RESET = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         if (bus.commandDone === 1'b1) done_cnt++;
      end
      check_val("no_done_after_rst", done_cnt, 0);
      run_txn(4'h6, 1'b0, 1'b0, 0, -1);

      // Busy flag stuck high.
      @(negedge CLK);
      bus.sendCommand_tick = 1'b1;
      bus.commandToSend    = 4'h2;
      bus.commandToSendRs  = 1'b0;
      bus.read_busy        = 1'b1;
      bus.lcd_data_in      = 4'hF;
      done_cnt = 0; done_at = -1; cyc = 0;
      while (cyc < 1000) begin
         @(negedge CLK);
         cyc++;
         bus.sendCommand_tick = 1'b0;
         if (bus.commandDone === 1'b1) begin
            done_cnt++;
            done_at = cyc;
         end
      end
`ifdef LCD_BUSY_TIMEOUT_EN
      check_val("timeout_done_count", done_cnt, 1);
      check_val("timeout_done_cycle", done_at, 1 + S + E + H + TO);
      check_val("timeout_flag", bus.busy_timeout, 1);
      run_txn(4'h7, 1'b1, 1'b0, 0, -1);
      check_val("timeout_sticky", bus.busy_timeout, 1);
`else
      check_val("stuck_done_count", done_cnt, 0);
      check_val("stuck_timeout_flag", bus.busy_timeout, 0);
`endif
      do_reset();
      @(negedge CLK);
      check_val("final_timeout_clear", bus.busy_timeout, 0);
      check_val("final_oe", bus.lcd_data_oe, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
